motion_bbox_detect: RTL and testbench

MOTION_BBOX_DETECT -- requirements
Module: motion_bbox_detect

---
 rtl/motion_bbox_detect.sv | 223 ++++++++++++++++++++++
 tb/tb_motion_bbox_detect.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/motion_bbox_detect.sv
// rtl/motion_bbox_detect.sv - frame-difference motion bounding box with RGB565 rectangle overlay
//
// Purpose: compares aligned current/previous gray samples against a per-frame
// threshold. It tracks the bounding box and pixel count of motion pixels, and
// commits them when the frame ends. The box committed from the previous frame
// is drawn on the pass-through video stream.
//
// Ports:
//   clk, rst_n                     pixel clock, asynchronous active-low reset
//   dvp_vsync/href/valid/data      incoming RGB565 video (frame, line, pixel strobe, pixel)
//   cur_gray, prev_gray            aligned gray samples of the current and previous frame
//   thresh                         difference threshold, sampled at frame start
//   overlay_en                     enables rectangle drawing
//   post_frame_vsync/href/clken    video controls, delayed by 2 clk
//   post_img_data                  pixel with overlay, delayed by 2 clk
//   bbox_left/right/top/bottom     committed box
//   bbox_valid                     committed box holds at least MIN_PIX motion pixels
//   motion_cnt                     motion pixels in the last completed frame
module motion_bbox_detect #(
  parameter int          IMG_HDISP = 640,
  parameter int          IMG_VDISP = 480,
  parameter int          PIX_W     = 8,
  parameter int          MIN_PIX   = 64,
  parameter logic [15:0] BOX_COLOR = 16'hF800
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     dvp_vsync,
  input  logic                                     dvp_href,
  input  logic                                     dvp_valid,
  input  logic [15:0]                              dvp_data,
  input  logic [PIX_W-1:0]                         cur_gray,
  input  logic [PIX_W-1:0]                         prev_gray,
  input  logic [PIX_W-1:0]                         thresh,
  input  logic                                     overlay_en,
  output logic                                     post_frame_vsync,
  output logic                                     post_frame_href,
  output logic                                     post_frame_clken,
  output logic [15:0]                              post_img_data,
  output logic [$clog2(IMG_HDISP)-1:0]             bbox_left,
  output logic [$clog2(IMG_HDISP)-1:0]             bbox_right,
  output logic [$clog2(IMG_VDISP)-1:0]             bbox_top,
  output logic [$clog2(IMG_VDISP)-1:0]             bbox_bottom,
  output logic                                     bbox_valid,
  output logic [$clog2(IMG_HDISP*IMG_VDISP+1)-1:0] motion_cnt
);

  localparam int XW  = $clog2(IMG_HDISP);
  localparam int YW  = $clog2(IMG_VDISP);
  localparam int XCW = XW + 1;
  localparam int YCW = YW + 1;
  localparam int CW  = $clog2(IMG_HDISP*IMG_VDISP+1);

  // Position counters are one bit wider and saturate at the frame size.
  // An out-of-range pixel or line then never aliases into the active area.
  localparam logic [XW:0]   X_END   = XCW'(IMG_HDISP);
  localparam logic [YW:0]   Y_END   = YCW'(IMG_VDISP);
  localparam logic [CW-1:0] MIN_CNT = CW'(MIN_PIX);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             vsync_q, href_q;
  logic [XW:0]      x_q, x_d;
  logic [YW:0]      y_q, y_d, y_cur;
  logic [PIX_W-1:0] thresh_q, thr_eff;
  logic [PIX_W:0]   diff;
  logic             vs_rise, vs_fall, hr_fall, start, in_range, motion;
  logic [CW-1:0]    cnt_q, cnt_d, mcnt_q, mcnt_d;
  logic [XW-1:0]    min_x_q, min_x_d, max_x_q, max_x_d, left_q, left_d, right_q, right_d;
  logic [YW-1:0]    min_y_q, min_y_d, max_y_q, max_y_d, top_q, top_d, bottom_q, bottom_d;
  logic             valid_q, valid_d;
  logic             on_col, on_row, hit;
  logic             s1_vs_q, s1_hr_q, s1_ck_q, s1_hit_q;
  logic [15:0]      s1_data_q;
  logic             pvs_q, phr_q, pck_q;
  logic [15:0]      pdata_q;

  always_comb begin
    vs_rise = dvp_vsync & ~vsync_q;
    vs_fall = ~dvp_vsync & vsync_q;
    hr_fall = ~dvp_href & href_q;
    // Frame start is also accepted in COMMIT. A one-cycle vsync gap then
    // loses nothing of the new frame.
    start   = vs_rise & (state_q != S_ACTIVE);
    y_cur   = vs_rise ? '0 : y_q;
    thr_eff = vs_rise ? thresh : thresh_q;

    diff = (cur_gray >= prev_gray) ? ({1'b0, cur_gray} - {1'b0, prev_gray})
                                   : ({1'b0, prev_gray} - {1'b0, cur_gray});
    in_range = (x_q < X_END) && (y_cur < Y_END);
    motion   = ((state_q == S_ACTIVE) | start) & dvp_vsync & dvp_href & dvp_valid
               & in_range & (diff > {1'b0, thr_eff});

    x_d = x_q;
    if (hr_fall) x_d = '0;
    else if (dvp_href && dvp_valid && x_q != X_END) x_d = x_q + 1'b1;
    y_d = y_q;
    if (vs_rise) y_d = '0;
    else if (hr_fall && y_q != Y_END) y_d = y_q + 1'b1;

    // Accumulator restarts on frame start, then takes in the current pixel.
    cnt_d   = start ? '0 : cnt_q;
    min_x_d = start ? '1 : min_x_q;
    max_x_d = start ? '0 : max_x_q;
    min_y_d = start ? '1 : min_y_q;
    max_y_d = start ? '0 : max_y_q;
    if (motion) begin
      if (cnt_d != '1) cnt_d = cnt_d + 1'b1;
      if (x_q[XW-1:0] < min_x_d) min_x_d = x_q[XW-1:0];
      if (x_q[XW-1:0] > max_x_d) max_x_d = x_q[XW-1:0];
      if (y_cur[YW-1:0] < min_y_d) min_y_d = y_cur[YW-1:0];
      if (y_cur[YW-1:0] > max_y_d) max_y_d = y_cur[YW-1:0];
    end

    state_d = state_q;
    case (state_q)
      S_IDLE:   if (vs_rise) state_d = S_ACTIVE;
      S_ACTIVE: if (vs_fall) state_d = S_COMMIT;
      S_COMMIT: state_d = vs_rise ? S_ACTIVE : S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    mcnt_d   = mcnt_q;
    valid_d  = valid_q;
    left_d   = left_q;
    right_d  = right_q;
    top_d    = top_q;
    bottom_d = bottom_q;
    if (state_q == S_COMMIT) begin
      mcnt_d  = cnt_q;
      valid_d = (cnt_q >= MIN_CNT);
      if (cnt_q >= MIN_CNT) begin
        left_d   = min_x_q;
        right_d  = max_x_q;
        top_d    = min_y_q;
        bottom_d = max_y_q;
      end
    end

    // The overlay uses the next-state box. A pixel in the commit cycle
    // belongs to the new frame and must see the box just committed.
    on_col = (({1'b0, left_d} == x_q) || ({1'b0, right_d} == x_q))
             && ({1'b0, top_d} <= y_cur) && (y_cur <= {1'b0, bottom_d});
    on_row = (({1'b0, top_d} == y_cur) || ({1'b0, bottom_d} == y_cur))
             && ({1'b0, left_d} <= x_q) && (x_q <= {1'b0, right_d});
    hit    = overlay_en & valid_d & dvp_vsync & dvp_href & dvp_valid & (on_col | on_row);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      // Treat vsync as already high. A frame in progress at reset release
      // then produces no rising edge and is never committed.
      vsync_q   <= 1'b1;
      href_q    <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      thresh_q  <= '0;
      cnt_q     <= '0;
      min_x_q   <= '1;
      max_x_q   <= '0;
      min_y_q   <= '1;
      max_y_q   <= '0;
      mcnt_q    <= '0;
      valid_q   <= 1'b0;
      left_q    <= '0;
      right_q   <= '0;
      top_q     <= '0;
      bottom_q  <= '0;
      s1_vs_q   <= 1'b0;
      s1_hr_q   <= 1'b0;
      s1_ck_q   <= 1'b0;
      s1_hit_q  <= 1'b0;
      s1_data_q <= '0;
      pvs_q     <= 1'b0;
      phr_q     <= 1'b0;
      pck_q     <= 1'b0;
      pdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      vsync_q   <= dvp_vsync;
      href_q    <= dvp_href;
      x_q       <= x_d;
      y_q       <= y_d;
      if (vs_rise) thresh_q <= thresh;
      cnt_q     <= cnt_d;
      min_x_q   <= min_x_d;
      max_x_q   <= max_x_d;
      min_y_q   <= min_y_d;
      max_y_q   <= max_y_d;
      mcnt_q    <= mcnt_d;
      valid_q   <= valid_d;
      left_q    <= left_d;
      right_q   <= right_d;
      top_q     <= top_d;
      bottom_q  <= bottom_d;
      s1_vs_q   <= dvp_vsync;
      s1_hr_q   <= dvp_href;
      s1_ck_q   <= dvp_valid;
      s1_hit_q  <= hit;
      s1_data_q <= dvp_data;
      pvs_q     <= s1_vs_q;
      phr_q     <= s1_hr_q;
      pck_q     <= s1_ck_q;
      pdata_q   <= s1_hit_q ? BOX_COLOR : s1_data_q;
    end
  end

  assign post_frame_vsync = pvs_q;
  assign post_frame_href  = phr_q;
  assign post_frame_clken = pck_q;
  assign post_img_data    = pdata_q;
  assign bbox_left        = left_q;
  assign bbox_right       = right_q;
  assign bbox_top         = top_q;
  assign bbox_bottom      = bottom_q;
  assign bbox_valid       = valid_q;
  assign motion_cnt       = mcnt_q;

endmodule

// File: tb/tb_motion_bbox_detect.sv
// tb/tb_motion_bbox_detect.sv - scoreboard bench for motion_bbox_detect on a reduced frame
module tb_motion_bbox_detect;
  localparam int H = 20, V = 12, PW = 8, MINP = 6;
  localparam logic [15:0] BOX = 16'hF800;
  localparam int XW = $clog2(H), YW = $clog2(V), CW = $clog2(H*V+1);
  localparam int M_STATIC = 0, M_MAP = 1, M_EQ = 2, M_EXT = 3;

  logic clk = 1'b0, rst_n = 1'b0;
  logic dvp_vsync, dvp_href, dvp_valid, overlay_en;
  logic [15:0] dvp_data;
  logic [PW-1:0] cur_gray, prev_gray, thresh;
  logic post_frame_vsync, post_frame_href, post_frame_clken, bbox_valid;
  logic [15:0] post_img_data;
  logic [XW-1:0] bbox_left, bbox_right;
  logic [YW-1:0] bbox_top, bbox_bottom;
  logic [CW-1:0] motion_cnt;

  always #5 clk = ~clk;

  motion_bbox_detect #(.IMG_HDISP(H), .IMG_VDISP(V), .PIX_W(PW), .MIN_PIX(MINP), .BOX_COLOR(BOX)) dut (
    .clk(clk), .rst_n(rst_n), .dvp_vsync(dvp_vsync), .dvp_href(dvp_href), .dvp_valid(dvp_valid),
    .dvp_data(dvp_data), .cur_gray(cur_gray), .prev_gray(prev_gray), .thresh(thresh),
    .overlay_en(overlay_en), .post_frame_vsync(post_frame_vsync), .post_frame_href(post_frame_href),
    .post_frame_clken(post_frame_clken), .post_img_data(post_img_data), .bbox_left(bbox_left),
    .bbox_right(bbox_right), .bbox_top(bbox_top), .bbox_bottom(bbox_bottom),
    .bbox_valid(bbox_valid), .motion_cnt(motion_cnt));

  typedef struct {
    int          due;
    logic        vs, hr, ck;
    logic [15:0] data;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int cyc = 0, errors = 0, checks = 0;

  // Reference model: committed result plus running statistics of the live frame
  bit m_valid, pend, live;
  int m_l, m_r, m_t, m_b, m_cnt;
  int f_cnt, f_x0, f_x1, f_y0, f_y1;
  int mode, thr, fixed_big;
  bit mot[V][H];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops one expectation per cycle at its due time
  always @(negedge clk) begin
    while (sbq.size() > 0 && sbq[0].due < cyc) begin
      checks++; errors++;
      $display("FAIL post_stream_missed due=%0d now=%0d", sbq[0].due, cyc);
      void'(sbq.pop_front());
    end
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      mon_e = sbq.pop_front();
      checks++;
      if ({post_frame_vsync, post_frame_href, post_frame_clken, post_img_data} !==
          {mon_e.vs, mon_e.hr, mon_e.ck, mon_e.data}) begin
        errors++;
        $display("FAIL post_stream cyc=%0d got v=%b h=%b c=%b d=%h expected v=%b h=%b c=%b d=%h",
                 cyc, post_frame_vsync, post_frame_href, post_frame_clken, post_img_data,
                 mon_e.vs, mon_e.hr, mon_e.ck, mon_e.data);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_commit();
    chk("motion_cnt", 64'(motion_cnt), 64'(m_cnt));
    chk("bbox_valid", 64'(bbox_valid), 64'(m_valid));
    chk("bbox_left", 64'(bbox_left), 64'(m_l));
    chk("bbox_right", 64'(bbox_right), 64'(m_r));
    chk("bbox_top", 64'(bbox_top), 64'(m_t));
    chk("bbox_bottom", 64'(bbox_bottom), 64'(m_b));
    pend = 1'b0;
  endtask

  task automatic drive(input logic vs, hr, ck, input logic [15:0] d, input logic [PW-1:0] cg, pg,
                       input logic ov, input logic [15:0] ed);
    exp_t e;
    @(posedge clk); #1;
    dvp_vsync = vs; dvp_href = hr; dvp_valid = ck; dvp_data = d;
    cur_gray = cg; prev_gray = pg; overlay_en = ov;
    e.due = cyc + 2; e.vs = vs; e.hr = hr; e.ck = ck; e.data = ed;
    sbq.push_back(e);
  endtask

  task automatic idle(input logic vs, input int n);
    logic [15:0] d;
    repeat (n) begin
      d = 16'($urandom);
      drive(vs, 1'b0, 1'b0, d, 8'($urandom), 8'($urandom), 1'b1, d);
    end
  endtask

  task automatic gen_px(input int x, y, output logic [PW-1:0] cg, pg);
    int d, p;
    bit in_r;
    in_r = (x < H) && (y < V);
    if (mode == M_EXT) begin cg = 8'd0; pg = 8'd255; return; end
    if (mode == M_EQ) d = thr;
    else if (!in_r || mot[y][x]) d = (fixed_big > 0) ? fixed_big : int'($urandom_range(255, thr + 1));
    else if (mode == M_STATIC) d = 0;
    else d = int'($urandom_range(thr, 0));
    p = int'($urandom_range(255 - d, 0));
    if ($urandom_range(1, 0) == 1) begin cg = 8'(p + d); pg = 8'(p); end
    else begin cg = 8'(p); pg = 8'(p + d); end
  endtask

  task automatic model_px(input int x, y, input logic [PW-1:0] cg, pg);
    int ad;
    ad = (cg > pg) ? int'(cg) - int'(pg) : int'(pg) - int'(cg);
    if (live && x < H && y < V && ad > thr) begin
      f_cnt++;
      if (x < f_x0) f_x0 = x;
      if (x > f_x1) f_x1 = x;
      if (y < f_y0) f_y0 = y;
      if (y > f_y1) f_y1 = y;
    end
  endtask

  function automatic logic [15:0] exp_pix(input logic ov, input int x, y, input logic [15:0] d);
    bit onp;
    onp = ((x == m_l || x == m_r) && y >= m_t && y <= m_b) ||
          ((y == m_t || y == m_b) && x >= m_l && x <= m_r);
    return (ov && m_valid && x < H && y < V && onp) ? BOX : d;
  endfunction

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_post", 64'({post_frame_vsync, post_frame_href, post_frame_clken, post_img_data}), 64'd0);
    chk("rst_bbox", 64'({bbox_left, bbox_right, bbox_top, bbox_bottom, bbox_valid}), 64'd0);
    chk("rst_motion_cnt", 64'(motion_cnt), 64'd0);
    sbq.delete();
    m_valid = 0; m_l = 0; m_r = 0; m_t = 0; m_b = 0; m_cnt = 0; live = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_frame(input int md, input int fthr, input bit do_rise, input int gap, input int rst_line);
    logic [PW-1:0] cg, pg;
    logic [15:0] d, ed;
    logic ov, ck;
    int x;
    mode = md; thr = fthr; live = do_rise;
    f_cnt = 0; f_x0 = 1 << 20; f_x1 = -1; f_y0 = 1 << 20; f_y1 = -1;
    thresh = 8'(fthr);
    if (do_rise) idle(1'b1, 2);
    for (int y = 0; y < V + 1; y++) begin
      ov = ($urandom_range(3, 0) != 0);
      x = 0;
      while (x < H + 2) begin
        ck = ($urandom_range(3, 0) != 0);
        d = 16'($urandom);
        if (ck) begin
          gen_px(x, y, cg, pg);
          model_px(x, y, cg, pg);
          ed = exp_pix(ov, x, y, d);
          x++;
        end else begin
          cg = 8'($urandom); pg = 8'($urandom); ed = d;
        end
        drive(1'b1, 1'b1, ck, d, cg, pg, ov, ed);
        if (y == rst_line && x == 7 && ck) do_reset();
      end
      idle(1'b1, 3);
      if (y == 0 && pend) check_commit();
      if (y == 0) thresh = 8'($urandom);
    end
    if (live) begin
      m_cnt = f_cnt;
      m_valid = (f_cnt >= MINP);
      if (m_valid) begin m_l = f_x0; m_r = f_x1; m_t = f_y0; m_b = f_y1; end
    end
    pend = 1'b1;
    idle(1'b0, gap);
  endtask

  task automatic clear_map();
    for (int y = 0; y < V; y++) for (int x = 0; x < H; x++) mot[y][x] = 1'b0;
  endtask

  task automatic set_block(input int x0, x1, y0, y1);
    for (int y = y0; y <= y1; y++) for (int x = x0; x <= x1; x++) mot[y][x] = 1'b1;
  endtask

  task automatic set_rand(input int pct);
    for (int y = 0; y < V; y++) for (int x = 0; x < H; x++) mot[y][x] = ($urandom_range(99, 0) < pct);
  endtask

  task automatic set_sparse(input int n);
    int k, x, y;
    k = 0;
    while (k < n) begin
      x = int'($urandom_range(H - 1, 0)); y = int'($urandom_range(V - 1, 0));
      if (!mot[y][x]) begin mot[y][x] = 1'b1; k++; end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    dvp_vsync = 1'b1; dvp_href = 1'b0; dvp_valid = 1'b0; dvp_data = '0;
    cur_gray = '0; prev_gray = '0; thresh = 8'd10; overlay_en = 1'b1;
    m_valid = 0; m_l = 0; m_r = 0; m_t = 0; m_b = 0; m_cnt = 0; pend = 0; fixed_big = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_post", 64'({post_frame_vsync, post_frame_href, post_frame_clken, post_img_data}), 64'd0);
    chk("reset_bbox", 64'({bbox_left, bbox_right, bbox_top, bbox_bottom, bbox_valid}), 64'd0);
    chk("reset_motion_cnt", 64'(motion_cnt), 64'd0);
    rst_n = 1'b1;

    clear_map(); set_rand(40); run_frame(M_MAP, 30, 1'b0, 4, -1);
    clear_map(); run_frame(M_STATIC, 30, 1'b1, 4, -1);
    run_frame(M_STATIC, 30, 1'b1, 4, -1);
    clear_map(); set_block(5, 14, 3, 8); fixed_big = 40; run_frame(M_MAP, 20, 1'b1, 4, -1); fixed_big = 0;
    chk("block_model_cnt", 64'(m_cnt), 64'd60);
    clear_map(); run_frame(M_STATIC, 15, 1'b1, 4, -1);
    run_frame(M_EQ, int'($urandom_range(200, 1)), 1'b1, 4, -1);
    clear_map(); set_block(2, 17, 1, 10); run_frame(M_MAP, 50, 1'b1, 4, -1);
    clear_map(); set_sparse(MINP - 1); run_frame(M_MAP, 60, 1'b1, 4, -1);
    clear_map(); set_block(7, 7, 2, 9); run_frame(M_MAP, 25, 1'b1, 4, -1);
    clear_map(); set_block(3, 15, 4, 4); run_frame(M_MAP, 25, 1'b1, 4, -1);
    for (int i = 0; i < 3; i++) begin
      clear_map(); set_rand(5 + 10 * i); run_frame(M_MAP, int'($urandom_range(200, 1)), 1'b1, 3, -1);
    end
    run_frame(M_EXT, 254, 1'b1, 4, -1);
    clear_map(); run_frame(M_STATIC, 40, 1'b1, 1, -1);
    clear_map(); set_block(4, 10, 6, 11); run_frame(M_MAP, 35, 1'b1, 1, -1);
    clear_map(); set_rand(20); run_frame(M_MAP, 70, 1'b1, 4, -1);
    clear_map(); set_block(1, 18, 0, 11); run_frame(M_MAP, 20, 1'b1, 4, 5);
    clear_map(); run_frame(M_STATIC, 20, 1'b1, 4, -1);
    clear_map(); set_block(6, 9, 2, 5); run_frame(M_MAP, 20, 1'b1, 4, -1);
    clear_map(); run_frame(M_STATIC, 20, 1'b1, 4, -1);
    idle(1'b0, 6);
    if (pend) check_commit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
